// File: rtl/mem_port_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and defaults for the memory port arbiter   |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

   localparam int N_REQ_DEF   = 3;
   localparam int DW_DEF      = 32;
   localparam int TIMEOUT_DEF = 255;
   localparam int CNT_W       = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } arb_state_t;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick  : combinational round-robin picker, search starts at ptr     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] ptr_i,
   output logic [N-1:0] grant_o
);

   logic [N-1:0] mask_hi;
   logic [N-1:0] req_hi;
   logic [N-1:0] pick_hi;
   logic [N-1:0] pick_lo;

   // Requests at or above the pointer bit win first; otherwise wrap to the lowest.
   assign mask_hi = ~(ptr_i - N'(1));
   assign req_hi  = req_i & mask_hi;
   assign pick_hi = req_hi & (~req_hi + N'(1));
   assign pick_lo = req_i & (~req_i + N'(1));
   assign grant_o = (|req_hi) ? pick_hi : pick_lo;

endmodule : rr_pick

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter : round-robin arbiter of N requesters onto one       |
// |                    memory port, with per-access timeout              |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req_valid_i,
   input  logic [N_REQ-1:0]  req_we_i,
   input  logic [N_REQ*DW-1:0] req_addr_i,
   input  logic [N_REQ*DW-1:0] req_wdata_i,
   output logic [N_REQ-1:0]  req_ready_o,
   output logic [N_REQ-1:0]  rsp_valid_o,
   output logic              rsp_err_o,
   output logic [DW-1:0]     rsp_rdata_o,
   output logic [N_REQ-1:0]  sel_onehot_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [DW-1:0]     mem_addr_o,
   output logic [DW-1:0]     mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DW-1:0]     mem_rdata_i
);

   arb_state_t       state_q;
   logic [N_REQ-1:0] ptr_q;
   logic [N_REQ-1:0] sel_onehot_q;
   logic [CNT_W-1:0] cnt_q;
   logic             mem_we_q;
   logic [DW-1:0]    mem_addr_q;
   logic [DW-1:0]    mem_wdata_q;

   logic [N_REQ-1:0] grant;
   logic [DW-1:0]    win_addr;
   logic [DW-1:0]    win_wdata;
   logic             in_wait;
   logic             timeout_hit;
   logic             done;

   rr_pick #(.N(N_REQ)) u_rr_pick (
      .req_i   (req_valid_i),
      .ptr_i   (ptr_q),
      .grant_o (grant)
   );

   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            win_addr  = req_addr_i[i*DW +: DW];
            win_wdata = req_wdata_i[i*DW +: DW];
         end
      end
   end

   // The strobe fires in the WAIT cycle whose count would reach TIMEOUT.
   assign in_wait     = (state_q == ST_WAIT);
   assign timeout_hit = in_wait && (cnt_q == CNT_W'(TIMEOUT - 1));
   assign done        = in_wait && (mem_ack_i || timeout_hit) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ptr_q        <= N_REQ'(1);
         sel_onehot_q <= '0;
         cnt_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|req_valid_i) begin
                  state_q      <= ST_WAIT;
                  sel_onehot_q <= grant;
                  mem_we_q     <= |(req_we_i & grant);
                  mem_addr_q   <= win_addr;
                  mem_wdata_q  <= win_wdata;
                  cnt_q        <= '0;
               end
            end
            ST_WAIT: begin
               if (mem_ack_i || timeout_hit) begin
                  state_q      <= ST_IDLE;
                  sel_onehot_q <= '0;
                  ptr_q        <= {sel_onehot_q[N_REQ-2:0], sel_onehot_q[N_REQ-1]};
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o  = (!in_wait && !rst) ? grant : '0;
   assign rsp_valid_o  = done ? sel_onehot_q : '0;
   assign rsp_err_o    = done && !mem_ack_i;
   assign rsp_rdata_o  = (done && mem_ack_i) ? mem_rdata_i : '0;
   assign sel_onehot_o = sel_onehot_q;
   assign mem_en_o     = in_wait;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench, TIMEOUT = 4       |
// | Revision            : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_we;
   logic [N*DW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  rsp_valid;
   logic          rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic [N-1:0]  sel_onehot;
   logic          mem_en;
   logic          mem_we;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_we_i     (req_we),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .req_ready_o  (req_ready),
      .rsp_valid_o  (rsp_valid),
      .rsp_err_o    (rsp_err),
      .rsp_rdata_o  (rsp_rdata),
      .sel_onehot_o (sel_onehot),
      .mem_en_o     (mem_en),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_ack_i    (mem_ack),
      .mem_rdata_i  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   logic [N-1:0]  exp_grant [4];
   logic [DW-1:0] exp_addr  [4];
   logic          exp_we    [4];

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_we    = 3'b010;
      req_addr  = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
      req_wdata = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
      mem_ack   = 1'b0;
      mem_rdata = '0;
      step();
      step();
      rst = 1'b0;
      settle();
      chk3("reset_sel", sel_onehot, 3'b000);
      chk1("reset_mem_en", mem_en, 1'b0);
      chk3("reset_ready", req_ready, 3'b000);
      chk3("reset_rsp_valid", rsp_valid, 3'b000);
      chk32("reset_mem_addr", mem_addr, 32'h0);
      chk1("reset_mem_we", mem_we, 1'b0);

      // All three request continuously; each access acked in its 2nd WAIT cycle.
      exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
      exp_addr  = '{32'h100, 32'h101, 32'h102, 32'h100};
      exp_we    = '{1'b0, 1'b1, 1'b0, 1'b0};
      step();
      req_valid = 3'b111;
      for (int g = 0; g < 4; g++) begin
         settle();
         chk3("rr_ready", req_ready, exp_grant[g]);
         chk1("rr_idle_mem_en", mem_en, 1'b0);
         step();
         settle();
         chk3("rr_sel", sel_onehot, exp_grant[g]);
         chk32("rr_mem_addr", mem_addr, exp_addr[g]);
         chk1("rr_mem_we", mem_we, exp_we[g]);
         chk1("rr_wait1_mem_en", mem_en, 1'b1);
         chk3("rr_wait1_ready", req_ready, 3'b000);
         chk3("rr_wait1_rsp", rsp_valid, 3'b000);
         step();
         mem_ack   = 1'b1;
         mem_rdata = 32'h0000_0011;
         settle();
         chk3("rr_rsp_valid", rsp_valid, exp_grant[g]);
         chk1("rr_rsp_err", rsp_err, 1'b0);
         chk32("rr_rsp_rdata", rsp_rdata, 32'h0000_0011);
         step();
         mem_ack = 1'b0;
      end
      req_valid = '0;
      step();

      // Requester 2 alone with mem_ack held high: grant every other cycle.
      req_valid = 3'b100;
      mem_ack   = 1'b1;
      mem_rdata = 32'h0000_0022;
      for (int g = 0; g < 3; g++) begin
         settle();
         chk3("solo_ready", req_ready, 3'b100);
         chk3("solo_idle_sel", sel_onehot, 3'b000);
         chk3("solo_idle_ack_ignored", rsp_valid, 3'b000);
         step();
         settle();
         chk3("solo_wait_sel", sel_onehot, 3'b100);
         chk3("solo_rsp_valid", rsp_valid, 3'b100);
         step();
      end
      req_valid = '0;
      mem_ack   = 1'b0;
      step();

      // Read returning DEADBEEF to requester 0; inputs dropped after acceptance.
      req_valid = 3'b001;
      req_we    = 3'b000;
      settle();
      chk3("read_ready", req_ready, 3'b001);
      step();
      req_valid = '0;
      req_addr  = '0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      settle();
      chk32("read_latched_addr", mem_addr, 32'h100);
      chk1("read_mem_we", mem_we, 1'b0);
      chk3("read_rsp_valid", rsp_valid, 3'b001);
      chk32("read_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk1("read_rsp_err", rsp_err, 1'b0);
      step();
      mem_ack = 1'b0;
      settle();
      chk3("read_after_rsp_valid", rsp_valid, 3'b000);
      chk32("read_after_rdata", rsp_rdata, 32'h0);

      // Timeout: requester 1, no ack, exactly 4 WAIT cycles.
      req_addr  = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
      req_valid = 3'b010;
      mem_rdata = 32'h1234_5678;
      settle();
      chk3("to_ready", req_ready, 3'b010);
      step();
      req_valid = '0;
      for (int w = 0; w < 3; w++) begin
         settle();
         chk1("to_wait_mem_en", mem_en, 1'b1);
         chk3("to_wait_rsp", rsp_valid, 3'b000);
         step();
      end
      settle();
      chk1("to_wait4_mem_en", mem_en, 1'b1);
      chk3("to_rsp_valid", rsp_valid, 3'b010);
      chk1("to_rsp_err", rsp_err, 1'b1);
      chk32("to_rsp_rdata", rsp_rdata, 32'h0);
      step();
      mem_ack = 1'b1;
      settle();
      chk1("to_idle_mem_en", mem_en, 1'b0);
      chk3("late_ack_rsp_valid", rsp_valid, 3'b000);
      chk1("late_ack_rsp_err", rsp_err, 1'b0);
      step();
      mem_ack = 1'b0;

      // Reset in the 2nd WAIT cycle abandons the access; pointer returns to 0.
      req_valid = 3'b100;
      settle();
      chk3("rstw_ready", req_ready, 3'b100);
      step();
      req_valid = '0;
      settle();
      chk1("rstw_wait1_mem_en", mem_en, 1'b1);
      step();
      rst = 1'b1;
      settle();
      chk3("rstw_rsp_during_rst", rsp_valid, 3'b000);
      step();
      rst     = 1'b0;
      mem_ack = 1'b1;
      settle();
      chk1("rstw_mem_en", mem_en, 1'b0);
      chk3("rstw_late_ack_rsp", rsp_valid, 3'b000);
      chk3("rstw_sel", sel_onehot, 3'b000);
      step();
      mem_ack   = 1'b0;
      req_valid = 3'b111;
      settle();
      chk3("rstw_next_grant", req_ready, 3'b001);
      step();
      req_valid = '0;
      mem_ack   = 1'b1;
      settle();
      chk3("rstw_rsp_valid", rsp_valid, 3'b001);
      step();
      mem_ack = 1'b0;

      // Ack in the same cycle as timeout expiry is a normal completion.
      req_valid = 3'b010;
      settle();
      chk3("tie_ready", req_ready, 3'b010);
      step();
      req_valid = '0;
      step();
      step();
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'h0000_0055;
      settle();
      chk3("tie_rsp_valid", rsp_valid, 3'b010);
      chk1("tie_rsp_err", rsp_err, 1'b0);
      chk32("tie_rsp_rdata", rsp_rdata, 32'h0000_0055);
      step();
      mem_ack = 1'b0;
      settle();
      chk1("tie_idle_mem_en", mem_en, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_port_arbiter

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters sharing the single memory port.
REQ-002 Parameter DW, default 32, address and data width.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before an error completion; 1..255.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 req_valid  in  N_REQ  per-requester access request.
REQ-007 req_we  in  N_REQ  per-requester write enable.
REQ-008 req_addr  in  N_REQ*DW  packed addresses; requester i occupies bits [i*DW +: DW].
REQ-009 req_wdata  in  N_REQ*DW  packed write data; same packing as req_addr.
REQ-010 req_ready  out  N_REQ  one-cycle acceptance strobe per requester.
REQ-011 rsp_valid  out  N_REQ  one-cycle completion strobe per requester.
REQ-012 rsp_err  out  1  qualifies rsp_valid; 1 means timeout.
REQ-013 rsp_rdata  out  DW  read data, valid with rsp_valid.
REQ-014 sel_onehot  out  N_REQ  registered one-hot owner select; drives the team's one-hot MUX selects.
REQ-015 mem_en, mem_we  out  1 each  memory strobe and write enable.
REQ-016 mem_addr, mem_wdata  out  DW each  registered address and write data.
REQ-017 mem_ack  in  1  memory completion; mem_rdata  in  DW  read data valid with mem_ack.

Function
REQ-018 FSM states: IDLE, WAIT; encoding comes from the shared package.
REQ-019 IDLE with any req_valid: pick the winner combinationally by round-robin, starting the search at the bit set in pointer ptr.
REQ-020 In that same cycle, assert req_ready for the winner only.
REQ-021 At the next edge: sel_onehot <= winner; latch mem_addr, mem_wdata and mem_we from the winner; go to WAIT; clear the timeout counter.
REQ-022 WAIT: mem_en=1; req_ready=0 for all requesters; new requests are held off, not queued.
REQ-023 WAIT with mem_ack=1: rsp_valid[owner]=1 and rsp_err=0 in the same cycle; rsp_rdata=mem_rdata; next state IDLE.
REQ-024 WAIT without mem_ack: counter increments each cycle.
REQ-025 When the counter reaches TIMEOUT without mem_ack: rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0; next state IDLE.
REQ-026 mem_ack arriving together with timeout expiry wins; it is reported as a normal completion.
REQ-027 On every completion, ptr <= sel_onehot rotated left by one with wrap (bit N_REQ-1 goes to bit 0); this gives the owner lowest priority.
REQ-028 sel_onehot clears to 0 on return to IDLE and is never multi-hot.
REQ-029 Latency: req_valid in IDLE at cycle t gives mem_en at t+1; mem_ack at t+k gives rsp_valid at t+k; the next grant is earliest at t+k+1.
REQ-030 mem_ack in IDLE is ignored; no rsp_valid is produced.
REQ-031 After req_ready, requester inputs are don't-care; the latched values are used.
REQ-032 All rsp_* outputs are 0 whenever no completion strobe is active.

Reset
REQ-033 rst=1 at an edge: state=IDLE, ptr=1 (requester 0 first), sel_onehot=0, counter=0, mem_addr/mem_wdata/mem_we=0.
REQ-034 Reset forces mem_en, req_ready, rsp_valid and rsp_err to 0 from the cycle after the edge; rst has priority over all other inputs.
REQ-035 Reset during WAIT abandons the transaction with no rsp_valid; any later mem_ack is ignored.

Structure
REQ-036 Package mem_arb_pkg holds the FSM state type, N_REQ/DW/TIMEOUT defaults and counter width (8).
REQ-037 Sub-module rr_pick (req vector, ptr -> one-hot winner) is purely combinational and is instantiated once.

Verification
REQ-038 Reset, then req_valid=3'b111 held: grants in order 001, 010, 100, 001; each acked after 2 cycles.
REQ-039 Only requester 2 requests continuously, ack immediate: it is granted every 2 cycles; sel_onehot alternates 100/000.
REQ-040 Read with mem_rdata=32'hDEADBEEF on ack: rsp_valid=001, rsp_rdata=32'hDEADBEEF, rsp_err=0.
REQ-041 TIMEOUT=4, no ack: exactly 4 WAIT cycles, then rsp_err=1 and rsp_rdata=0; a late mem_ack in IDLE produces nothing.
REQ-042 rst asserted in the 2nd WAIT cycle, then mem_ack: no rsp_valid; the next grant goes to requester 0.
REQ-043 mem_ack in the same cycle the counter hits TIMEOUT: rsp_err=0.
